// File: rtl/la_linedrv.sv
// la_linedrv: single-wire bidirectional line master (drive, turnaround, sample).
// Optional even-parity bit on both directions via `define LA_LINEDRV_PARITY_EN.
module la_linedrv #(
  parameter int    DW     = 8,
  parameter int    BITCYC = 4,
  parameter int    TA     = 2,
  parameter string PROP   = "DEFAULT"
) (
  input  logic          clk,
  input  logic          reset,
  inout  wire           z,
  input  logic          tx_valid,
  output logic          tx_ready,
  input  logic [DW-1:0] tx_data,
  output logic          rx_valid,
  output logic [DW-1:0] rx_data,
  output logic          rx_perr,
  output logic          busy
);

`ifdef LA_LINEDRV_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = DW + PB;
  localparam int CW = $clog2(BITCYC + 1);
  localparam int BW = $clog2(DW + 2);
  localparam int TW = $clog2(TA + 1);
  localparam logic [CW-1:0] CLAST = CW'(BITCYC - 1);
  localparam logic [BW-1:0] BLAST = BW'(NB - 1);
  localparam logic [TW-1:0] TLAST = TW'(TA - 1);

  typedef enum logic [2:0] {
    IDLE, DRIVE, TURN, SAMPLE, DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cyc;
  logic [BW-1:0]   bitc;
  logic [TW-1:0]   tac;
  logic [NB-1:0]   tx_sh;
  logic [DW-1:0]   rx_sh;
  logic [DW-1:0]   rx_nx;
  logic [NB-1:0]   tx_load;

  assign z     = (state == DRIVE) ? tx_sh[0] : 1'bz;
  assign rx_nx = DW'({z, rx_sh} >> 1);

`ifdef LA_LINEDRV_PARITY_EN
  assign tx_load = {^tx_data, tx_data};
`else
  assign tx_load = tx_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cyc      <= '0;
      bitc     <= '0;
      tac      <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_perr  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (tx_valid) begin
            tx_sh    <= tx_load;
            cyc      <= '0;
            bitc     <= '0;
            state    <= DRIVE;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        DRIVE: begin
          if (cyc == CLAST) begin
            cyc   <= '0;
            tx_sh <= tx_sh >> 1;
            if (bitc == BLAST) begin
              bitc  <= '0;
              tac   <= '0;
              state <= TURN;
            end else begin
              bitc <= bitc + 1'b1;
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        TURN: begin
          if (tac == TLAST) begin
            tac   <= '0;
            state <= SAMPLE;
          end else begin
            tac <= tac + 1'b1;
          end
        end
        SAMPLE: begin
          if (cyc == CLAST) begin
            cyc <= '0;
            // the last sample of the frame goes straight to the outputs
            if (bitc == BLAST) begin
              bitc     <= '0;
              state    <= DONE;
              rx_valid <= 1'b1;
`ifdef LA_LINEDRV_PARITY_EN
              rx_data  <= rx_sh;
              rx_perr  <= (^rx_sh) ^ z;
`else
              rx_sh    <= rx_nx;
              rx_data  <= rx_nx;
              rx_perr  <= 1'b0;
`endif
            end else begin
              rx_sh <= rx_nx;
              bitc  <= bitc + 1'b1;
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          rx_valid <= 1'b0;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_la_linedrv.sv
// tb_la_linedrv: directed + random transfers against a cycle-schedule model,
// with a bench-side responder and keeper on the shared line.
module tb_la_linedrv;
  localparam int DW = 8;
  localparam int BITCYC = 4;
  localparam int TA = 2;
`ifdef LA_LINEDRV_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = DW + PB;
  localparam int D = NB * BITCYC;
  localparam int LAT = 2 * D + TA + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] tx_data;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          rx_perr;
  logic          busy;
  wire           z;

  logic kp_en = 1'b0;
  logic kp_val = 1'b0;
  logic rsp_en = 1'b0;
  logic rsp_bit = 1'b0;

  assign z = kp_en ? kp_val : 1'bz;
  assign z = rsp_en ? rsp_bit : 1'bz;
  wire z_rel = (z === 1'bz);

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  la_linedrv #(
    .DW(DW), .BITCYC(BITCYC), .TA(TA), .PROP("DEFAULT")
  ) dut (
    .clk(clk), .reset(reset), .z(z),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_perr(rx_perr),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one full transfer, checked cycle by cycle against the frame schedule
  task automatic xfer(input logic [DW-1:0] tx, input logic [DW-1:0] nxt,
                      input bit hold, input bit keep,
                      input logic [DW-1:0] rsp, input logic rpar);
    logic [NB-1:0] txf;
    logic [NB-1:0] rsf;
    logic [DW-1:0] exp_data;
    logic          exp_perr;
    int            n;
`ifdef LA_LINEDRV_PARITY_EN
    txf = {^tx, tx};
    rsf = {rpar, rsp};
`else
    txf = tx;
    rsf = rsp;
`endif
    exp_data = keep ? {DW{txf[NB-1]}} : rsp;
`ifdef LA_LINEDRV_PARITY_EN
    exp_perr = (^exp_data) ^ (keep ? txf[NB-1] : rpar);
`else
    exp_perr = 1'b0;
`endif
    if (!tx_valid) begin
      tx_valid = 1'b1;
      tx_data  = tx;
    end
    n = 0;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 200), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
    for (int c = 1; c <= LAT + 1; c++) begin
      rsp_en = 1'b0;
      kp_en  = 1'b0;
      if (c > D && c <= LAT - 1) kp_en = keep;
      if (c > D + TA && c <= LAT - 1 && !keep) begin
        rsp_en  = 1'b1;
        rsp_bit = rsf[(c - D - TA - 1) / BITCYC];
      end
      if (hold && c == 5) tx_data = DW'($urandom);
      if (hold && c == LAT) tx_data = nxt;
      @(negedge clk);
      if (c <= D) begin
        chk("drive_z", 32'(z), 32'(txf[(c - 1) / BITCYC]));
        chk("drive_oe", 32'(z_rel), 32'd0);
        kp_val = z;
      end else if (!keep && c <= D + TA) begin
        chk("turn_z", 32'(z_rel), 32'd1);
      end
      chk("busy", 32'(busy), 32'(c <= LAT));
      chk("tx_ready", 32'(tx_ready), 32'(c == LAT + 1));
      chk("rx_valid", 32'(rx_valid), 32'(c == LAT));
      if (c == LAT) begin
        chk("rx_data", 32'(rx_data), 32'(exp_data));
        chk("rx_perr", 32'(rx_perr), 32'(exp_perr));
      end
      if (c == LAT + 1) begin
        chk("idle_z", 32'(z_rel), 32'd1);
        chk("rx_hold", 32'(rx_data), 32'(exp_data));
      end
      if (c <= LAT) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_z", 32'(z_rel), 32'd1);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_perr", 32'(rx_perr), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_z", 32'(z_rel), 32'd1);
      chk("idle_ready", 32'(tx_ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_rx_valid", 32'(rx_valid), 32'd0);
    end

    xfer(8'hA5, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0);
    xfer(8'h80, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
    xfer(8'h01, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);

    xfer(8'h01, 8'h02, 1'b1, 1'b0, 8'h5A, 1'b1);
    xfer(8'h02, 8'h03, 1'b1, 1'b0, 8'hC3, 1'b0);
    xfer(8'h03, 8'h00, 1'b0, 1'b0, 8'h81, 1'b1);

`ifdef LA_LINEDRV_PARITY_EN
    xfer(8'h07, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1);
    xfer(8'h07, 8'h00, 1'b0, 1'b0, 8'h03, 1'b0);
`endif

    for (int i = 0; i < 6; i++) begin
      xfer(DW'($urandom), 8'h00, 1'b0, ($urandom_range(3) == 0),
           DW'($urandom), 1'($urandom));
    end

    // abort in the tenth drive cycle
    tx_valid = 1'b1;
    tx_data  = DW'($urandom);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_z", 32'(z_rel), 32'd1);
    chk("abort_ready", 32'(tx_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rx_data", 32'(rx_data), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (rx_valid || busy) seen = 1'b1;
    end
    chk("abort_no_rx", 32'(seen), 32'd0);

    xfer(8'h3C, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
